// File: rtl/a2910_pkg.sv
// a2910_pkg: opcode enum and default sizes for the a2910 microprogram sequencer.
package a2910_pkg;
  localparam int A2910_W     = 12;
  localparam int A2910_DEPTH = 5;
  typedef enum logic [3:0] {
    JZ, CJS, JMAP, CJP, PUSH, JSRP, CJV, JRP,
    RFCT, RPCT, CRTN, CJPP, LDCT, LOOP, CONT, TWB
  } seq_op_t;
endpackage

// File: rtl/a2910_stack.sv
// a2910_stack: subroutine/loop stack with pointer, full flag and sticky error.
// Error detection exists only when A2910_STKERR_EN is defined.
module a2910_stack import a2910_pkg::*; #(
  parameter int W     = A2910_W,
  parameter int DEPTH = A2910_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_clr,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_tos,
  output logic         o_full,
  output logic         o_err
);
  localparam int SPW = $clog2(DEPTH + 1);
  logic [SPW-1:0] r_sp;
  logic [W-1:0]   r_stk [DEPTH];
  logic           w_full, w_empty;
  logic [SPW-1:0] w_rd, w_wr;
  assign w_full  = r_sp == SPW'(DEPTH);
  assign w_empty = r_sp == '0;
  assign w_rd    = w_empty ? '0 : r_sp - 1'b1;
  assign w_wr    = w_full ? SPW'(DEPTH - 1) : r_sp;
  assign o_tos   = r_stk[w_rd];
  assign o_full  = w_full;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sp <= '0;
      for (int k = 0; k < DEPTH; k++) r_stk[k] <= '0;
    end else if (i_clr) begin
      r_sp <= '0;
    end else if (i_push) begin
      r_stk[w_wr] <= i_din;
      if (!w_full) r_sp <= r_sp + 1'b1;
    end else if (i_pop && !w_empty) begin
      r_sp <= r_sp - 1'b1;
    end
`ifdef A2910_STKERR_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_err <= 1'b0;
    else if ((i_push && w_full) || (i_pop && !i_clr && w_empty)) r_err <= 1'b1;
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif
endmodule

// File: rtl/a2910.sv
// a2910: Am2910-compatible microprogram sequencer (decode, uPC, counter R, output mux).
// Define A2910_STKERR_EN to enable sticky stack overflow/underflow reporting on stkerr.
module a2910 import a2910_pkg::*; #(
  parameter int W     = A2910_W,
  parameter int DEPTH = A2910_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   i,
  input  logic [W-1:0] d,
  input  logic         ccbar,
  input  logic         ccenbar,
  input  logic         ci,
  input  logic         rldbar,
  input  logic         OEbar,
  output logic [W-1:0] y,
  output logic         fullbar,
  output logic         plbar,
  output logic         mapbar,
  output logic         vectbar,
  output logic         stkerr
);
  logic [W-1:0] r_upc, r_r, w_y, w_tos;
  logic w_pass, w_zero, w_push, w_pop, w_clr, w_ld, w_dec, w_full;
  assign w_pass = ccenbar | ~ccbar;
  assign w_zero = r_r == '0;
  always_comb begin
    w_y    = r_upc;
    w_push = 1'b0;
    w_pop  = 1'b0;
    w_clr  = 1'b0;
    w_ld   = 1'b0;
    w_dec  = 1'b0;
    case (seq_op_t'(i))
      JZ:   begin w_y = '0; w_clr = 1'b1; end
      CJS:  if (w_pass) begin w_y = d; w_push = 1'b1; end
      JMAP: w_y = d;
      CJP:  w_y = w_pass ? d : r_upc;
      PUSH: begin w_push = 1'b1; w_ld = w_pass; end
      JSRP: begin w_y = w_pass ? d : r_r; w_push = 1'b1; end
      CJV:  w_y = w_pass ? d : r_upc;
      JRP:  w_y = w_pass ? d : r_r;
      RFCT: if (!w_zero) begin w_y = w_tos; w_dec = 1'b1; end else w_pop = 1'b1;
      RPCT: if (!w_zero) begin w_y = d; w_dec = 1'b1; end
      CRTN: if (w_pass) begin w_y = w_tos; w_pop = 1'b1; end
      CJPP: if (w_pass) begin w_y = d; w_pop = 1'b1; end
      LDCT: w_ld = 1'b1;
      LOOP: if (w_pass) w_pop = 1'b1; else w_y = w_tos;
      CONT: w_y = r_upc;
      TWB:  if (!w_zero && !w_pass) begin w_y = w_tos; w_dec = 1'b1; end
            else begin w_y = (w_zero && !w_pass) ? d : r_upc; w_pop = 1'b1; end
      default: w_y = r_upc;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_upc <= '0;
      r_r   <= '0;
    end else begin
      r_upc <= w_y + W'(ci);
      r_r   <= (!rldbar || w_ld) ? d : w_dec ? r_r - 1'b1 : r_r;
    end
  a2910_stack #(.W(W), .DEPTH(DEPTH)) u_stack (
    .clk(clk), .rst_n(rst_n), .i_push(w_push), .i_pop(w_pop), .i_clr(w_clr),
    .i_din(r_upc), .o_tos(w_tos), .o_full(w_full), .o_err(stkerr)
  );
  assign fullbar = ~w_full;
  assign mapbar  = i != 4'(JMAP);
  assign vectbar = i != 4'(CJV);
  assign plbar   = ~(mapbar & vectbar);
  assign y       = OEbar ? {W{1'bz}} : w_y;
endmodule

// File: tb/tb_a2910.sv
// tb_a2910: directed self-checking bench for the a2910 sequencer.
module tb_a2910;
  import a2910_pkg::*;
  logic clk = 1'b0, rst_n;
  logic [3:0] i;
  logic [11:0] d, y;
  logic ccbar, ccenbar, ci, rldbar, OEbar;
  logic fullbar, plbar, mapbar, vectbar, stkerr;
  int n_pass = 0, n_total = 0;
  a2910 dut (
    .clk(clk), .rst_n(rst_n), .i(i), .d(d), .ccbar(ccbar), .ccenbar(ccenbar),
    .ci(ci), .rldbar(rldbar), .OEbar(OEbar), .y(y), .fullbar(fullbar),
    .plbar(plbar), .mapbar(mapbar), .vectbar(vectbar), .stkerr(stkerr)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic chk_y(input string nm, input logic [11:0] e);
    n_total++;
    if (y !== e) $display("FAIL %s: y=%h expected %h", nm, y, e);
    else n_pass++;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; i = 4'(CONT); d = '0; ccbar = 1'b1; ccenbar = 1'b1;
    ci = 1'b1; rldbar = 1'b1; OEbar = 1'b0;
    #1;
    chk_y("reset_y", 12'h000);
    n_total++;
    if (fullbar !== 1'b1 || stkerr !== 1'b0) $display("FAIL reset_flags: fullbar=%b stkerr=%b expected 1 0", fullbar, stkerr);
    else n_pass++;
    rst_n = 1'b1;
    OEbar = 1'b1; #1;
    chk_y("oe_tristate", 12'hzzz);
    OEbar = 1'b0; #1;
  endtask
  task automatic test_cont;
    for (int k = 0; k < 3; k++) begin
      chk_y("cont", 12'(k));
      n_total++;
      if (plbar !== 1'b0) $display("FAIL cont_plbar: plbar=%b expected 0", plbar);
      else n_pass++;
      tick;
    end
  endtask
  task automatic test_cjs_crtn;
    i = 4'(CJP); d = 12'h00F; #1; chk_y("cjp_pass", 12'h00F); tick;
    i = 4'(CJS); d = 12'h200; #1; chk_y("cjs_pass", 12'h200); tick;
    i = 4'(CRTN); d = 12'h0; #1; chk_y("crtn_pass", 12'h010); tick;
    i = 4'(CONT); #1; chk_y("after_crtn", 12'h011);
    n_total++;
    if (dut.u_stack.r_sp !== 3'd0) $display("FAIL crtn_sp: sp=%0d expected 0", dut.u_stack.r_sp);
    else n_pass++;
    tick;
  endtask
  task automatic test_rpct;
    i = 4'(LDCT); d = 12'h002; #1; chk_y("ldct", 12'h012); tick;
    i = 4'(RPCT); d = 12'h050; #1; chk_y("rpct1", 12'h050); tick;
    #1; chk_y("rpct2", 12'h050); tick;
    #1; chk_y("rpct_zero", 12'h051); tick;
    n_total++;
    if (dut.r_r !== 12'h000) $display("FAIL rpct_r: R=%h expected 000", dut.r_r);
    else n_pass++;
  endtask
  task automatic test_push_full;
    i = 4'(PUSH); d = 12'h000;
    for (int k = 0; k < 6; k++) begin
      #1; chk_y("push_y", 12'h052 + 12'(k));
      tick;
      n_total++;
      if (fullbar !== (k < 4)) $display("FAIL push_fullbar[%0d]: fullbar=%b expected %b", k, fullbar, k < 4);
      else n_pass++;
    end
    i = 4'(LOOP); ccenbar = 1'b0; ccbar = 1'b1; #1;
    chk_y("overwrite_tos", 12'h057);
    n_total++;
`ifdef A2910_STKERR_EN
    if (stkerr !== 1'b1) $display("FAIL stkerr: stkerr=%b expected 1", stkerr);
`else
    if (stkerr !== 1'b0) $display("FAIL stkerr: stkerr=%b expected 0", stkerr);
`endif
    else n_pass++;
    tick;
    i = 4'(JZ); #1; chk_y("jz", 12'h000); tick;
    n_total++;
    if (fullbar !== 1'b1) $display("FAIL jz_fullbar: fullbar=%b expected 1", fullbar);
    else n_pass++;
  endtask
  task automatic test_cond;
    i = 4'(CJP); d = 12'h3FF; #1; chk_y("cjp_fail", 12'h001);
    n_total++;
    if ({plbar, mapbar, vectbar} !== 3'b011) $display("FAIL strobes_cjp: %b expected 011", {plbar, mapbar, vectbar});
    else n_pass++;
    tick;
    i = 4'(JMAP); d = 12'h123; #1; chk_y("jmap", 12'h123);
    n_total++;
    if ({plbar, mapbar, vectbar} !== 3'b101) $display("FAIL strobes_jmap: %b expected 101", {plbar, mapbar, vectbar});
    else n_pass++;
    tick;
    i = 4'(CJV); d = 12'h0AB; #1; chk_y("cjv_fail", 12'h124);
    n_total++;
    if ({plbar, mapbar, vectbar} !== 3'b110) $display("FAIL strobes_cjv: %b expected 110", {plbar, mapbar, vectbar});
    else n_pass++;
    tick;
    ccbar = 1'b0; #1; chk_y("cjv_pass", 12'h0AB); tick;
    i = 4'(LDCT); d = 12'h077; #1; chk_y("ldct2", 12'h0AC); tick;
    i = 4'(JRP); ccbar = 1'b1; d = 12'h100; #1; chk_y("jrp_fail", 12'h077); tick;
    i = 4'(RPCT); rldbar = 1'b0; d = 12'h005; #1; chk_y("rpct_rld", 12'h005); tick;
    rldbar = 1'b1;
    n_total++;
    if (dut.r_r !== 12'h005) $display("FAIL rld_override: R=%h expected 005", dut.r_r);
    else n_pass++;
  endtask
  task automatic test_twb_async;
    i = 4'(LDCT); d = 12'h000; #1; chk_y("ldct0", 12'h006); tick;
    i = 4'(PUSH); #1; chk_y("push_fail", 12'h007); tick;
    i = 4'(TWB); d = 12'h2AA; #1; chk_y("twb_zero_fail", 12'h2AA); tick;
    n_total++;
    if (dut.u_stack.r_sp !== 3'd0) $display("FAIL twb_pop: sp=%0d expected 0", dut.u_stack.r_sp);
    else n_pass++;
    i = 4'(LDCT); d = 12'h055; #1; chk_y("ldct55", 12'h2AB); tick;
    i = 4'(CONT); #1;
    rst_n = 1'b0; #1;
    n_total++;
    if (dut.r_upc !== 12'h0 || dut.r_r !== 12'h0 || dut.u_stack.r_sp !== 3'd0)
      $display("FAIL async_reset: upc=%h R=%h sp=%0d expected 0 0 0", dut.r_upc, dut.r_r, dut.u_stack.r_sp);
    else n_pass++;
    chk_y("async_reset_y", 12'h000);
    rst_n = 1'b1; #1;
  endtask
  initial begin
    test_reset;
    test_cont;
    test_cjs_crtn;
    test_rpct;
    test_push_full;
    test_cond;
    test_twb_async;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
